br_resolve_update: RTL

Branch resolution and BTB update unit. Sits after the two execute-stage branch ports and produces the front end's redirect/flush and the BTB update stream that the BTB predictor consumes on its update port. It compares each resolved branch with the prediction it carried down the pipe. It buffers up to two BTB writes per cycle in a FIFO and drains them one per cycle into the BTB's single write port. It back-pressures execute when the FIFO cannot absorb a worst-case cycle.

---
 rtl/br_resolve_update.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/br_resolve_update.sv
// Branch resolution and BTB update unit: compares resolved branches with their
// predictions, issues redirect/flush, and queues BTB writes drained one per cycle.
module br_resolve_update #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        ex0_valid,
    input  logic [29:0] ex0_pc,
    input  logic [1:0]  ex0_br_type,
    input  logic        ex0_taken,
    input  logic [29:0] ex0_target,
    input  logic [1:0]  ex0_pred_type,
    input  logic [29:0] ex0_pred_npc,

    input  logic        ex1_valid,
    input  logic [29:0] ex1_pc,
    input  logic [1:0]  ex1_br_type,
    input  logic        ex1_taken,
    input  logic [29:0] ex1_target,
    input  logic [1:0]  ex1_pred_type,
    input  logic [29:0] ex1_pred_npc,

    output logic        redirect,
    output logic [29:0] redirect_pc,
    output logic        flush,
    output logic        upd_valid,
    output logic [29:0] upd_pc,
    output logic [1:0]  upd_br_type,
    output logic [29:0] upd_br_target,
    output logic        stall_ex,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_miss_cnt,
    output logic        fifo_ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [29:0] pc;
        logic [1:0]  br_type;
        logic [29:0] target;
    } upd_t;

    upd_t           mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           redirect_q, redirect_d;
    logic [29:0]    redirect_pc_q, redirect_pc_d;
    logic [31:0]    br_cnt_q, br_cnt_d;
    logic [31:0]    miss_cnt_q, miss_cnt_d;
    logic           ovf_q, ovf_d;

    logic [29:0]    npc0, npc1;
    logic           miss0, miss1, need0, need1, v1, br0, br1;
    logic           deq;
    logic [1:0]     n_enq, n_acc;
    logic [CW-1:0]  space;
    upd_t           ent0, ent1, first_e, second_e;

    // Port 1 is on the wrong path whenever port 0 mispredicts.
    always_comb begin
        npc0  = (ex0_br_type != 2'b00 && ex0_taken) ? ex0_target : ex0_pc + 30'd1;
        npc1  = (ex1_br_type != 2'b00 && ex1_taken) ? ex1_target : ex1_pc + 30'd1;
        miss0 = ex0_valid && (npc0 != ex0_pred_npc);
        v1    = ex1_valid && !miss0;
        miss1 = v1 && (npc1 != ex1_pred_npc);
        need0 = ex0_valid && ex0_br_type != 2'b00 && ex0_taken &&
                (ex0_pred_type != ex0_br_type || ex0_pred_npc != ex0_target);
        need1 = v1 && ex1_br_type != 2'b00 && ex1_taken &&
                (ex1_pred_type != ex1_br_type || ex1_pred_npc != ex1_target);
        br0   = ex0_valid && ex0_br_type != 2'b00;
        br1   = v1 && ex1_br_type != 2'b00;
    end

    always_comb begin
        redirect_d    = miss0 || miss1;
        redirect_pc_d = miss0 ? npc0 : (miss1 ? npc1 : 30'd0);
        br_cnt_d      = br_cnt_q + {31'd0, br0} + {31'd0, br1};
        miss_cnt_d    = miss_cnt_q + {31'd0, redirect_d};
    end

    // The head pops every non-empty cycle, so its slot is free for this cycle's writes.
    always_comb begin
        ent0     = '{pc: ex0_pc, br_type: ex0_br_type, target: ex0_target};
        ent1     = '{pc: ex1_pc, br_type: ex1_br_type, target: ex1_target};
        first_e  = need0 ? ent0 : ent1;
        second_e = ent1;
        deq      = (count_q != '0);
        n_enq    = {1'b0, need0} + {1'b0, need1};
        space    = CW'(FIFO_DEPTH) - count_q + CW'(deq);
        ovf_d    = ovf_q;
        n_acc    = n_enq;
        if (CW'(n_enq) > space) begin
            n_acc = space[1:0];
            ovf_d = 1'b1;
        end
        count_d  = count_q + CW'(n_acc) - CW'(deq);
        wr_ptr_d = wr_ptr_q + PW'(n_acc);
        rd_ptr_d = rd_ptr_q + PW'(deq);
    end

    always_ff @(posedge clk) begin
        if (n_acc != 2'd0) mem[wr_ptr_q] <= first_e;
        if (n_acc == 2'd2) mem[wr_ptr_q + PW'(1)] <= second_e;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            miss_cnt_q    <= '0;
            ovf_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            ovf_q         <= ovf_d;
        end
    end

    always_comb begin
        redirect      = redirect_q;
        flush         = redirect_q;
        redirect_pc   = redirect_pc_q;
        upd_valid     = deq;
        upd_pc        = deq ? mem[rd_ptr_q].pc      : 30'd0;
        upd_br_type   = deq ? mem[rd_ptr_q].br_type : 2'd0;
        upd_br_target = deq ? mem[rd_ptr_q].target  : 30'd0;
        stall_ex      = count_q > CW'(FIFO_DEPTH - 2);
        perf_br_cnt   = br_cnt_q;
        perf_miss_cnt = miss_cnt_q;
        fifo_ovf      = ovf_q;
    end

endmodule
